// File: rtl/pf_issue_pkg.sv
// Shared types and widths for the prefetch issue queue slice.
package pf_issue_pkg;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = 16;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } pf_issue_state_t;
endpackage

// File: rtl/pf_sync_fifo.sv
// Single-clock FIFO holding pending prefetch addresses; head_data shows the oldest entry.
module pf_sync_fifo
   import pf_issue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = ADDR_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign do_push   = push & ~full & ~clear;
   assign do_pop    = pop & ~empty & ~clear;
   assign head_data = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end
endmodule

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: filters repeats, queues addresses, issues one memory request at a time.
// Optional recent-address filter enabled by defining PF_ISSUE_FILTER_EN.
module prefetch_issue_queue
   import pf_issue_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int FILT_N = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pf_valid,
   input  logic [ADDR_W-1:0] pf_addr,
   output logic              pf_ready,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  issued_count,
   output logic [CNT_W-1:0]  dropped_count
);
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic              fifo_full;
   logic              fifo_empty;
   logic              accept;
   logic              filt_hit;
   logic              enq;
   logic              pop;
   logic [ADDR_W-1:0] head;

   assign pf_ready = ~fifo_full;
   assign accept   = pf_valid & ~fifo_full & ~flush;
   assign enq      = accept & ~filt_hit;

   pf_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (flush),
      .push      (enq),
      .pop       (pop),
      .push_data (pf_addr),
      .head_data (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef PF_ISSUE_FILTER_EN
   localparam int FP_W = (FILT_N > 1) ? $clog2(FILT_N) : 1;

   logic [ADDR_W-1:0] filt_addr_q [FILT_N];
   logic [FILT_N-1:0] filt_vld_q;
   logic [FP_W-1:0]   filt_ptr_q;
   logic [CNT_W-1:0]  dropped_q;

   always_comb begin
      filt_hit = 1'b0;
      for (int i = 0; i < FILT_N; i++) begin
         if (filt_vld_q[i] && (filt_addr_q[i] == pf_addr)) filt_hit = 1'b1;
      end
   end

   // A hit leaves the filter untouched; only enqueued addresses displace the oldest entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         filt_vld_q <= '0;
         filt_ptr_q <= '0;
         dropped_q  <= '0;
      end else begin
         if (flush) begin
            filt_vld_q <= '0;
            filt_ptr_q <= '0;
         end else if (enq) begin
            filt_vld_q[filt_ptr_q] <= 1'b1;
            filt_ptr_q <= (filt_ptr_q == FP_W'(FILT_N - 1)) ? '0 : filt_ptr_q + 1'b1;
         end
         if (accept && filt_hit) dropped_q <= sat_inc(dropped_q);
      end
   end

   always_ff @(posedge clock) begin
      if (enq) filt_addr_q[filt_ptr_q] <= pf_addr;
   end

   assign dropped_count = dropped_q;
`else
   localparam int unused_filt_n = FILT_N;

   assign filt_hit      = 1'b0;
   assign dropped_count = '0;
`endif

   pf_issue_state_t   state_q;
   pf_issue_state_t   state_d;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [CNT_W-1:0]  issued_q;
   logic [CNT_W-1:0]  issued_d;

   // Flush suppresses pops so the queue is empty next cycle; an outstanding request still waits for its ack.
   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      issued_d   = issued_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && !flush) begin
               pop        = 1'b1;
               mem_addr_d = head;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               issued_d = sat_inc(issued_q);
               if (!fifo_empty && !flush) begin
                  pop        = 1'b1;
                  mem_addr_d = head;
               end else begin
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         issued_q   <= '0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= (state_d == REQ);
         mem_addr_q <= mem_addr_d;
         issued_q   <= issued_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_addr     = mem_addr_q;
   assign issued_count = issued_q;
endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Directed scoreboard bench for prefetch_issue_queue; follows PF_ISSUE_FILTER_EN like the design.
module tb_prefetch_issue_queue;
   localparam int DEPTH  = 8;
   localparam int FILT_N = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        pf_valid;
   logic [31:0] pf_addr;
   logic        pf_ready;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [15:0] issued_count;
   logic [15:0] dropped_count;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   int          exp_issued  = 0;
   int          exp_dropped = 0;
   logic [31:0] mf_a [FILT_N];
   bit          mf_v [FILT_N];
   int          mf_p = 0;

   prefetch_issue_queue #(
      .DEPTH  (DEPTH),
      .FILT_N (FILT_N)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .pf_valid      (pf_valid),
      .pf_addr       (pf_addr),
      .pf_ready      (pf_ready),
      .flush         (flush),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .issued_count  (issued_count),
      .dropped_count (dropped_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear_filter();
      for (int i = 0; i < FILT_N; i++) mf_v[i] = 1'b0;
      mf_p = 0;
   endtask

   task automatic model_accept(input logic [31:0] a);
      bit hit;
      hit = 1'b0;
`ifdef PF_ISSUE_FILTER_EN
      for (int i = 0; i < FILT_N; i++) if (mf_v[i] && mf_a[i] == a) hit = 1'b1;
`endif
      if (hit) begin
         exp_dropped++;
      end else begin
         exp_q.push_back(a);
         mf_a[mf_p] = a;
         mf_v[mf_p] = 1'b1;
         mf_p = (mf_p + 1) % FILT_N;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push(input logic [31:0] a);
      int n;
      n = 0;
      pf_valid = 1'b1;
      pf_addr  = a;
      while (!pf_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!pf_ready) check("push_ready", pf_ready, 1'b1);
      else model_accept(a);
      @(posedge clock); #1;
      pf_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         mem_ack = mem_req;
         @(posedge clock); #1;
         n++;
      end
      mem_ack = 1'b0;
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic do_flush();
      logic [31:0] keep;
      flush = 1'b1;
      if (mem_req && exp_q.size() != 0) begin
         keep = exp_q[0];
         exp_q.delete();
         exp_q.push_back(keep);
      end else begin
         exp_q.delete();
      end
      model_clear_filter();
      @(posedge clock); #1;
      flush = 1'b0;
   endtask

   // Scoreboard: a handshake seen here completes at the following rising edge.
   always @(negedge clock) begin
      if (!reset && mem_req && mem_ack) begin
         if (exp_q.size() == 0) begin
            check("unexpected_issue", mem_addr, 32'hFFFF_FFFF);
         end else begin
            check("issue_addr", mem_addr, exp_q.pop_front());
         end
         exp_issued++;
      end
   end

   initial begin
      reset    = 1'b1;
      pf_valid = 1'b0;
      pf_addr  = '0;
      flush    = 1'b0;
      mem_ack  = 1'b0;
      model_clear_filter();
      repeat (2) @(posedge clock);
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_pf_ready", pf_ready, 1);
      check("rst_issued", issued_count, 0);
      check("rst_dropped", dropped_count, 0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Single request with one-edge latency
      push(32'h0D);
      @(posedge clock); #1;
      check("lat_req", mem_req, 1);
      check("lat_addr", mem_addr, 32'h0D);
      mem_ack = 1'b1;
      @(posedge clock); #1;
      mem_ack = 1'b0;
      check("single_req_drop", mem_req, 0);
      check("single_issued", issued_count, 1);

      // Order with stall, then back-to-back acks
      push(32'h04);
      push(32'h0C);
      push(32'h0E);
      repeat (5) begin
         @(posedge clock); #1;
         check("stall_req", mem_req, 1);
         check("stall_addr", mem_addr, 32'h04);
      end
      mem_ack = 1'b1;
      @(posedge clock); #1;
      check("b2b_req1", mem_req, 1);
      check("b2b_addr1", mem_addr, 32'h0C);
      @(posedge clock); #1;
      check("b2b_req2", mem_req, 1);
      check("b2b_addr2", mem_addr, 32'h0E);
      @(posedge clock); #1;
      mem_ack = 1'b0;
      check("order_idle", mem_req, 0);
      check("order_issued", issued_count, exp_issued);

      // Ack while idle is ignored
      mem_ack = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      mem_ack = 1'b0;
      check("idle_ack_issued", issued_count, 4);
      check("idle_ack_req", mem_req, 0);

      // Filter scenario from a clean filter
      do_flush();
      push(32'h0D);
      push(32'h0D);
      push(32'h16);
      drain();
      check("filt_issued", issued_count, exp_issued);
      check("filt_dropped", dropped_count, exp_dropped);
`ifdef PF_ISSUE_FILTER_EN
      check("filt_dropped_abs", dropped_count, 1);
`else
      check("filt_dropped_abs", dropped_count, 0);
`endif

      // Full queue: no acks, tenth address must wait for a pop
      for (int i = 0; i < 9; i++) push(32'h100 + i);
      check("full_ready", pf_ready, 0);
      pf_valid = 1'b1;
      pf_addr  = 32'h109;
      repeat (3) begin
         @(posedge clock); #1;
         check("full_held", pf_ready, 0);
      end
      mem_ack = 1'b1;
      @(posedge clock); #1;
      mem_ack = 1'b0;
      check("full_freed", pf_ready, 1);
      push(32'h109);
      drain();
      check("full_issued", issued_count, exp_issued);

      // Flush while a request is outstanding
      push(32'h01);
      push(32'h02);
      push(32'h03);
      check("flush_pre_req", mem_req, 1);
      check("flush_pre_addr", mem_addr, 32'h01);
      do_flush();
      check("flush_hold_req", mem_req, 1);
      check("flush_hold_addr", mem_addr, 32'h01);
      check("flush_ready", pf_ready, 1);
      mem_ack = 1'b1;
      @(posedge clock); #1;
      mem_ack = 1'b0;
      repeat (3) begin
         check("flush_idle", mem_req, 0);
         @(posedge clock); #1;
      end
      check("flush_issued", issued_count, exp_issued);
      push(32'h01);
      drain();
      check("flush_repush_drop", dropped_count, exp_dropped);
      check("flush_repush_iss", issued_count, exp_issued);

      // Asynchronous reset in the middle of a request
      push(32'h55);
      push(32'h56);
      check("rreq_pre", mem_req, 1);
      #3;
      reset = 1'b1;
      #1;
      check("rreq_req", mem_req, 0);
      check("rreq_addr", mem_addr, 0);
      check("rreq_issued", issued_count, 0);
      check("rreq_dropped", dropped_count, 0);
      check("rreq_ready", pf_ready, 1);
      exp_q.delete();
      exp_issued  = 0;
      exp_dropped = 0;
      model_clear_filter();
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("post_rst_idle", mem_req, 0);
      push(32'h77);
      drain();
      check("post_rst_issued", issued_count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
